// File: rtl/current_pi_if.sv
// Handshake and data bundle for the dq current PI controller.
// The vlim member exists only when CURRENT_PI_LIMIT_EN is defined.
interface current_pi_if;
  logic               start;
  logic               clr;
  logic signed [15:0] id;
  logic signed [15:0] iq;
  logic signed [15:0] id_ref;
  logic signed [15:0] iq_ref;
  logic        [15:0] kp;
  logic        [15:0] ki;
`ifdef CURRENT_PI_LIMIT_EN
  logic        [15:0] vlim;
`endif
  logic signed [15:0] vd;
  logic signed [15:0] vq;
  logic               done;
  logic               busy;

  modport master (
`ifdef CURRENT_PI_LIMIT_EN
    output vlim,
`endif
    output start, clr,
    output id, iq, id_ref, iq_ref,
    output kp, ki,
    input  vd, vq, done, busy
  );

  modport slave (
`ifdef CURRENT_PI_LIMIT_EN
    input  vlim,
`endif
    input  start, clr,
    input  id, iq, id_ref, iq_ref,
    input  kp, ki,
    output vd, vq, done, busy
  );
endinterface

// File: rtl/current_pi.sv
// Sequential dq-axis PI current controller, one shared 17x17 multiplier.
// Define CURRENT_PI_LIMIT_EN to add a runtime voltage limit (bus.vlim).
module current_pi (
  input  logic         clk,
  input  logic         rst_n,
  current_pi_if.slave  bus
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_DP   = 3'd1;
  localparam logic [2:0] S_DI   = 3'd2;
  localparam logic [2:0] S_QP   = 3'd3;
  localparam logic [2:0] S_QI   = 3'd4;
  localparam logic [2:0] S_OUT  = 3'd5;

  logic        [2:0]  state_q, state_d;
  logic signed [16:0] errd_q, errd_d;
  logic signed [16:0] errq_q, errq_d;
  logic        [15:0] kp_q, kp_d;
  logic        [15:0] ki_q, ki_d;
  logic signed [15:0] pd_q, pd_d;
  logic signed [15:0] pq_q, pq_d;
  logic signed [15:0] accd_q, accd_d;
  logic signed [15:0] accq_q, accq_d;
  logic signed [15:0] vd_q, vd_d;
  logic signed [15:0] vq_q, vq_d;
  logic               done_q, done_d;
  logic        [15:0] lim;

`ifdef CURRENT_PI_LIMIT_EN
  logic        [15:0] lim_q, lim_d;
  assign lim = lim_q;
`else
  assign lim = 16'h7FFF;
`endif

  logic signed [16:0] mul_a;
  logic signed [16:0] mul_b;
  logic signed [33:0] prod;
  logic signed [33:0] shr;

  // Clamp a wide signed value symmetrically to +/-l.
  function automatic logic signed [15:0] sat(
    input logic signed [33:0] x,
    input logic        [15:0] l
  );
    logic signed [33:0] hi;
    hi = $signed({18'd0, l});
    if (x > hi)
      sat = $signed(l);
    else if (x < -hi)
      sat = -$signed(l);
    else
      sat = x[15:0];
  endfunction

  function automatic logic signed [33:0] ext(
    input logic signed [15:0] v
  );
    ext = {{18{v[15]}}, v};
  endfunction

  // Operand routing for the shared multiplier.
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    unique case (1'b1)
      state_q == S_DP: begin
        mul_a = errd_q;
        mul_b = $signed({1'b0, kp_q});
      end
      state_q == S_DI: begin
        mul_a = errd_q;
        mul_b = $signed({1'b0, ki_q});
      end
      state_q == S_QP: begin
        mul_a = errq_q;
        mul_b = $signed({1'b0, kp_q});
      end
      state_q == S_QI: begin
        mul_a = errq_q;
        mul_b = $signed({1'b0, ki_q});
      end
      default: ;
    endcase
  end

  assign prod = mul_a * mul_b;
  assign shr  = prod >>> 12;

  always_comb begin
    state_d = state_q;
    errd_d  = errd_q;
    errq_d  = errq_q;
    kp_d    = kp_q;
    ki_d    = ki_q;
    pd_d    = pd_q;
    pq_d    = pq_q;
    accd_d  = accd_q;
    accq_d  = accq_q;
    vd_d    = vd_q;
    vq_d    = vq_q;
    done_d  = 1'b0;
`ifdef CURRENT_PI_LIMIT_EN
    lim_d   = lim_q;
`endif
    if (bus.clr) begin
      state_d = S_IDLE;
      accd_d  = '0;
      accq_d  = '0;
      vd_d    = '0;
      vq_d    = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            errd_d  = {bus.id_ref[15], bus.id_ref}
                    - {bus.id[15], bus.id};
            errq_d  = {bus.iq_ref[15], bus.iq_ref}
                    - {bus.iq[15], bus.iq};
            kp_d    = bus.kp;
            ki_d    = bus.ki;
`ifdef CURRENT_PI_LIMIT_EN
            lim_d   = bus.vlim[15] ? 16'h7FFF : bus.vlim;
`endif
            state_d = S_DP;
          end
        end
        S_DP: begin
          pd_d    = sat(shr, lim);
          state_d = S_DI;
        end
        S_DI: begin
          // Sum at full width so the clamp sees the true value.
          accd_d  = sat(ext(accd_q) + shr, lim);
          state_d = S_QP;
        end
        S_QP: begin
          pq_d    = sat(shr, lim);
          state_d = S_QI;
        end
        S_QI: begin
          accq_d  = sat(ext(accq_q) + shr, lim);
          state_d = S_OUT;
        end
        S_OUT: begin
          vd_d    = sat(ext(pd_q) + ext(accd_q), lim);
          vq_d    = sat(ext(pq_q) + ext(accq_q), lim);
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      errd_q  <= '0;
      errq_q  <= '0;
      kp_q    <= '0;
      ki_q    <= '0;
      pd_q    <= '0;
      pq_q    <= '0;
      accd_q  <= '0;
      accq_q  <= '0;
      vd_q    <= '0;
      vq_q    <= '0;
      done_q  <= 1'b0;
`ifdef CURRENT_PI_LIMIT_EN
      lim_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      errd_q  <= errd_d;
      errq_q  <= errq_d;
      kp_q    <= kp_d;
      ki_q    <= ki_d;
      pd_q    <= pd_d;
      pq_q    <= pq_d;
      accd_q  <= accd_d;
      accq_q  <= accq_d;
      vd_q    <= vd_d;
      vq_q    <= vq_d;
      done_q  <= done_d;
`ifdef CURRENT_PI_LIMIT_EN
      lim_q   <= lim_d;
`endif
    end
  end

  assign bus.vd   = vd_q;
  assign bus.vq   = vq_q;
  assign bus.done = done_q;
  assign bus.busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_current_pi.sv
// Randomised self-checking bench for current_pi.
// Reference model works on plain longint arithmetic.
module tb_current_pi;

  logic clk;
  logic rst_n;

  current_pi_if bus ();

  current_pi dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nvec;
  int nbad;

  longint m_lim;
  longint m_accd;
  longint m_accq;
  longint m_vd;
  longint m_vq;

  task automatic chk(input string tag, input longint got,
                     input longint exp);
    nvec++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint msat(input longint x, input longint l);
    if (x > l) return l;
    if (x < -l) return -l;
    return x;
  endfunction

  task automatic model_clear();
    m_accd = 0;
    m_accq = 0;
    m_vd   = 0;
    m_vq   = 0;
  endtask

  // One full computation on the values currently on the bus.
  task automatic model_step();
    longint ed, eq, kp, ki, pd, pq;
`ifdef CURRENT_PI_LIMIT_EN
    m_lim = (bus.vlim > 32767) ? 32767 : longint'(bus.vlim);
`else
    m_lim = 32767;
`endif
    ed = longint'(bus.id_ref) - longint'(bus.id);
    eq = longint'(bus.iq_ref) - longint'(bus.iq);
    kp = longint'(bus.kp);
    ki = longint'(bus.ki);
    pd = msat((ed * kp) >>> 12, m_lim);
    pq = msat((eq * kp) >>> 12, m_lim);
    m_accd = msat(m_accd + ((ed * ki) >>> 12), m_lim);
    m_accq = msat(m_accq + ((eq * ki) >>> 12), m_lim);
    m_vd = msat(pd + m_accd, m_lim);
    m_vq = msat(pq + m_accq, m_lim);
  endtask

  task automatic set_in(input int idr, input int id, input int iqr,
                        input int iq, input int kp, input int ki);
    bus.id_ref = 16'(idr);
    bus.id     = 16'(id);
    bus.iq_ref = 16'(iqr);
    bus.iq     = 16'(iq);
    bus.kp     = 16'(kp);
    bus.ki     = 16'(ki);
  endtask

  task automatic do_clr();
    bus.clr = 1'b1;
    @(negedge clk);
    bus.clr = 1'b0;
    model_clear();
  endtask

  // Called at a negedge; pulses start and checks the full transaction.
  task automatic run_one();
    int lat;
    lat = 0;
    model_step();
    bus.start = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) begin
        bus.start = 1'b0;
        chk("busy_rise", bus.busy, 1);
      end
      if (bus.done) begin
        lat = k;
        break;
      end
    end
    chk("latency", lat, 6);
    chk("busy_drop", bus.busy, 0);
    chk("vd", bus.vd, m_vd);
    chk("vq", bus.vq, m_vq);
    @(negedge clk);
    chk("done_width", bus.done, 0);
  endtask

  initial begin
    int lat, ndone;
    nvec = 0;
    nbad = 0;
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.clr = 1'b0;
    set_in(0, 0, 0, 0, 0, 0);
`ifdef CURRENT_PI_LIMIT_EN
    bus.vlim = 16'hFFFF;
`endif
    model_clear();
    repeat (3) @(negedge clk);
    chk("rst_vd", bus.vd, 0);
    chk("rst_vq", bus.vq, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_busy", bus.busy, 0);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("idle_done", bus.done, 0);
    end

    // Pure proportional, unity gain.
    set_in(1000, 0, -500, 0, 'h1000, 0);
    run_one();
    chk("p_unity_vd", bus.vd, 1000);
    chk("p_unity_vq", bus.vq, -500);

    // Integrator ramp with ki = 0.5.
    do_clr();
    set_in(1000, 0, 0, 0, 0, 'h0800);
    for (int i = 0; i < 3; i++) begin
      run_one();
      chk("ki_ramp", bus.vd, 500 * (i + 1));
    end

    // Extreme error with large kp saturates symmetrically.
    do_clr();
    set_in(32767, -32768, 0, 0, 'h7FFF, 0);
    run_one();
    chk("sat_pos", bus.vd, 32767);
    set_in(-32768, 32767, 0, 0, 'h7FFF, 0);
    run_one();
    chk("sat_neg", bus.vd, -32767);

    // A second start during D_I must be ignored.
    do_clr();
    set_in(300, -20, -700, 45, 'h1800, 'h0400);
    model_step();
    bus.start = 1'b1;
    lat = 0;
    ndone = 0;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (k == 1) bus.start = 1'b0;
      if (k == 2) begin
        bus.start = 1'b1;
        bus.id_ref = 16'sd9000;
      end
      if (k == 3) bus.start = 1'b0;
      if (bus.done) begin
        ndone++;
        if (ndone == 1) begin
          lat = k;
          chk("ign_vd", bus.vd, m_vd);
          chk("ign_vq", bus.vq, m_vq);
        end
      end
    end
    chk("ign_latency", lat, 6);
    chk("ign_ndone", ndone, 1);

    // clr during Q_P aborts and zeroes everything.
    set_in(2000, 0, 1500, 0, 'h1000, 'h1000);
    bus.start = 1'b1;
    ndone = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 1) bus.start = 1'b0;
      if (k == 3) bus.clr = 1'b1;
      if (k == 4) bus.clr = 1'b0;
      if (bus.done) ndone++;
    end
    model_clear();
    chk("clr_ndone", ndone, 0);
    chk("clr_vd", bus.vd, 0);
    chk("clr_vq", bus.vq, 0);
    chk("clr_busy", bus.busy, 0);
    set_in(100, 0, -100, 0, 0, 'h1000);
    run_one();
    chk("clr_accd", bus.vd, 100);
    chk("clr_accq", bus.vq, -100);

    // start held high: one result every 6 clocks.
    set_in(-50, 10, 80, -5, 'h0C00, 'h0200);
    bus.start = 1'b1;
    for (int k = 1; k <= 26; k++) begin
      @(negedge clk);
      if (k == 13) bus.start = 1'b0;
      if (k <= 18 && k % 6 == 0) begin
        model_step();
        chk("b2b_done", bus.done, 1);
        chk("b2b_busy", bus.busy, 0);
        chk("b2b_vd", bus.vd, m_vd);
        chk("b2b_vq", bus.vq, m_vq);
      end else begin
        chk("b2b_nodone", bus.done, 0);
      end
    end

    // Reset mid-computation discards it.
    set_in(1234, 0, 4321, 0, 'h1000, 'h1000);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    ndone = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus.done) ndone++;
    end
    chk("rst_mid_ndone", ndone, 0);
    chk("rst_mid_vd", bus.vd, 0);
    chk("rst_mid_vq", bus.vq, 0);

`ifdef CURRENT_PI_LIMIT_EN
    // Runtime limit clamps the integrator with no windup.
    do_clr();
    bus.vlim = 16'd1000;
    set_in(800, 0, 0, 0, 0, 'h1000);
    run_one();
    chk("lim_1", bus.vd, 800);
    run_one();
    chk("lim_2", bus.vd, 1000);
    run_one();
    chk("lim_3", bus.vd, 1000);
    set_in(-200, 0, 0, 0, 0, 'h1000);
    run_one();
    chk("lim_unwind", bus.vd, 800);
`endif

    // Randomised traffic.
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 7) == 0) do_clr();
      set_in(int'($urandom), int'($urandom),
             int'($urandom), int'($urandom),
             ($urandom_range(0, 2) == 0) ? int'($urandom)
                                         : int'($urandom_range(0, 'h2000)),
             ($urandom_range(0, 2) == 0) ? int'($urandom)
                                         : int'($urandom_range(0, 'h0800)));
      if ($urandom_range(0, 1) == 0) begin
        bus.id_ref = 16'($signed(12'($urandom)));
        bus.id     = 16'($signed(12'($urandom)));
        bus.iq_ref = 16'($signed(12'($urandom)));
        bus.iq     = 16'($signed(12'($urandom)));
      end
`ifdef CURRENT_PI_LIMIT_EN
      bus.vlim = 16'($urandom);
`endif
      run_one();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
